// File: rtl/hv_dispatch_pkg.sv
// hv_dispatch_pkg: shared types for the bind command dispatcher.
// Holds the FSM state enum and the queued command bundle.
package hv_dispatch_pkg;

    localparam int HV_ADDR_WIDTH = 20;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACK  = 2'd1,
        S_WAIT_DONE = 2'd2
    } DispatchState_t;

    typedef struct packed {
        logic [HV_ADDR_WIDTH-1:0] vec_length;
        logic [HV_ADDR_WIDTH-1:0] hva;
        logic [HV_ADDR_WIDTH-1:0] hvb;
        logic [HV_ADDR_WIDTH-1:0] hvc;
    } BindCmd_t;

endpackage

// File: rtl/hv_cmd_fifo.sv
// hv_cmd_fifo: show-ahead synchronous FIFO of bind commands.
// Wrapping pointers; a separate count drives full/empty/level.
module hv_cmd_fifo
    import hv_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  BindCmd_t                    push_data,
    input  logic                        pop,
    output BindCmd_t                    head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    BindCmd_t          mem [FIFO_DEPTH];
    logic     [PW-1:0] wr_ptr;
    logic     [PW-1:0] rd_ptr;
    logic     [LW-1:0] count;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == LW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bind_command_dispatcher.sv
// bind_command_dispatcher: queues bind commands and issues them to the mapper.
// Optional per-command watchdog when DISPATCH_TIMEOUT_EN is defined.
module bind_command_dispatcher
    import hv_dispatch_pkg::*;
#(
    parameter int HV_ADDRESS_WIDTH = HV_ADDR_WIDTH,
    parameter int FIFO_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_vec_length,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_hva,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_hvb,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_hvc,
    output logic                        map_valid,
    output logic [HV_ADDRESS_WIDTH-1:0] map_vec_length,
    output logic [HV_ADDRESS_WIDTH-1:0] map_hva,
    output logic [HV_ADDRESS_WIDTH-1:0] map_hvb,
    output logic [HV_ADDRESS_WIDTH-1:0] map_hvc,
    input  logic                        map_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 completed_count
`ifdef DISPATCH_TIMEOUT_EN
    ,
    output logic                        timeout
`endif
);

    DispatchState_t state;
    DispatchState_t state_nxt;
    BindCmd_t       push_cmd;
    BindCmd_t       head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic           zero_len;
    logic           issue;
    logic           retire;
    logic           drop;
    logic           wd_expired;

    // Pack host operands into the queued command bundle.
    always_comb begin
        push_cmd            = '0;
        push_cmd.vec_length = HV_ADDR_WIDTH'(cmd_vec_length);
        push_cmd.hva        = HV_ADDR_WIDTH'(cmd_hva);
        push_cmd.hvb        = HV_ADDR_WIDTH'(cmd_hvb);
        push_cmd.hvc        = HV_ADDR_WIDTH'(cmd_hvc);
    end

    hv_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (state != S_IDLE) || !fifo_empty;
    assign zero_len  = (head.vec_length == '0);
    assign fifo_pop  = retire || drop;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_W   = (WD_RAW > 16) ? WD_RAW : 16;

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign wd_expired = (state != S_IDLE) &&
                        (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout    = timeout_q;

    // Watchdog: restarts on issue, runs while a command is outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (issue) begin
                wd_cnt <= '0;
            end else if (state != S_IDLE) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (drop) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_expired         = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: a completion seen with the watchdog still wins.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty && !zero_len && map_done) begin
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (wd_expired) begin
                    state_nxt = S_IDLE;
                end else if (!map_done) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (map_done || wd_expired) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: issue strobe, normal retire, watchdog drop.
    always_comb begin
        issue  = 1'b0;
        retire = 1'b0;
        drop   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (zero_len) begin
                        retire = 1'b1;
                    end else if (map_done) begin
                        issue = 1'b1;
                    end
                end
            end
            S_WAIT_ACK: begin
                drop = wd_expired;
            end
            S_WAIT_DONE: begin
                if (map_done) begin
                    retire = 1'b1;
                end else begin
                    drop = wd_expired;
                end
            end
            default: begin
                issue = 1'b0;
            end
        endcase
    end

    // Mapper operand registers, one-cycle strobe and retire counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map_valid       <= 1'b0;
            map_vec_length  <= '0;
            map_hva         <= '0;
            map_hvb         <= '0;
            map_hvc         <= '0;
            completed_count <= '0;
        end else begin
            map_valid <= issue;
            if (issue) begin
                map_vec_length <= HV_ADDRESS_WIDTH'(head.vec_length);
                map_hva        <= HV_ADDRESS_WIDTH'(head.hva);
                map_hvb        <= HV_ADDRESS_WIDTH'(head.hvb);
                map_hvc        <= HV_ADDRESS_WIDTH'(head.hvc);
            end
            if (retire) begin
                completed_count <= completed_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bind_command_dispatcher.sv
// tb_bind_command_dispatcher: randomized self-checking bench.
// A mapper model answers strobes; a queue model predicts issue order.
module tb_bind_command_dispatcher;

    localparam int W  = 20;
    localparam int FD = 4;

    typedef struct packed {
        logic [W-1:0] len;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } cmd_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_vec_length;
    logic [W-1:0] cmd_hva;
    logic [W-1:0] cmd_hvb;
    logic [W-1:0] cmd_hvc;
    logic         map_valid;
    logic [W-1:0] map_vec_length;
    logic [W-1:0] map_hva;
    logic [W-1:0] map_hvb;
    logic [W-1:0] map_hvc;
    logic         map_done;
    logic         busy;
    logic [2:0]   fifo_level;
    logic [15:0]  completed_count;
`ifdef DISPATCH_TIMEOUT_EN
    logic         timeout;
`endif

    logic mdl_done;
    logic hold_low;
    int   busy_cycles;
    bit   rand_busy;
    cmd_t issued[$];
    int   pulses;
    int   long_strobes;
    bit   prev_valid;
    int   exp_completed;
    int   n_cmp;
    int   n_fail;

    assign map_done = mdl_done && !hold_low;

    always #5 clk = ~clk;

    bind_command_dispatcher #(
        .HV_ADDRESS_WIDTH (W),
        .FIFO_DEPTH       (FD),
        .TIMEOUT_CYCLES   (20)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_vec_length  (cmd_vec_length),
        .cmd_hva         (cmd_hva),
        .cmd_hvb         (cmd_hvb),
        .cmd_hvc         (cmd_hvc),
        .map_valid       (map_valid),
        .map_vec_length  (map_vec_length),
        .map_hva         (map_hva),
        .map_hvb         (map_hvb),
        .map_hvc         (map_hvc),
        .map_done        (map_done),
        .busy            (busy),
        .fifo_level      (fifo_level),
        .completed_count (completed_count)
`ifdef DISPATCH_TIMEOUT_EN
        ,
        .timeout         (timeout)
`endif
    );

    // Strobe monitor: records each issued operand set.
    always @(negedge clk) begin
        if (map_valid) begin
            issued.push_back(cmd_t'({map_vec_length, map_hva,
                                     map_hvb, map_hvc}));
            pulses++;
            if (prev_valid) long_strobes++;
        end
        prev_valid = map_valid;
    end

    // Mapper model: drops done a cycle after the strobe, busy for a while.
    initial begin
        int k;
        int lim;
        mdl_done = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (map_valid) begin
                @(posedge clk); #1;
                mdl_done = 1'b0;
                lim = rand_busy ? int'($urandom_range(1, 6)) : 0;
                k = 0;
                while (k < (rand_busy ? lim : busy_cycles)) begin
                    @(posedge clk); #1;
                    k++;
                end
                mdl_done = 1'b1;
            end
        end
    end

    task automatic push_cmd(input cmd_t c);
        bit acc = 1'b0;
        cmd_vec_length = c.len;
        cmd_hva        = c.a;
        cmd_hvb        = c.b;
        cmd_hvc        = c.c;
        cmd_valid      = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            bit r = cmd_ready;
            @(posedge clk); #1;
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL push_accept: got no accept, required accept");
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (!busy && map_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_idle: got busy, required idle in 500 cycles");
        end
    endtask

    function automatic cmd_t rnd_cmd(input bit allow_zero);
        cmd_t c;
        c.len = W'($urandom_range(1, 1023));
        if (allow_zero && $urandom_range(0, 3) == 0) c.len = '0;
        c.a = W'($urandom);
        c.b = W'($urandom);
        c.c = W'($urandom);
        return c;
    endfunction

    task automatic test_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready: got %b required 1", cmd_ready);
        end
        n_cmp++;
        if ({map_valid, map_vec_length, map_hva, map_hvb, map_hvc} !== '0) begin
            n_fail++;
            $display("FAIL rst_map: got v=%b len=%0h required all 0",
                     map_valid, map_vec_length);
        end
        n_cmp++;
        if ({busy, fifo_level, completed_count} !== '0) begin
            n_fail++;
            $display("FAIL rst_status: got busy=%b lvl=%0d cnt=%0d required 0",
                     busy, fifo_level, completed_count);
        end
`ifdef DISPATCH_TIMEOUT_EN
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_timeout: got %b required 0", timeout);
        end
`endif
        reset_n = 1'b1;
        exp_completed = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        cmd_t c;
        int   p0 = pulses;
        c = cmd_t'({W'(8), W'('h100), W'('h200), W'('h300)});
        busy_cycles = 10;
        issued.delete();
        push_cmd(c);
        n_cmp++;
        if (map_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: got valid=%b required 0", map_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (map_valid !== 1'b1 ||
            cmd_t'({map_vec_length, map_hva, map_hvb, map_hvc}) !== c) begin
            n_fail++;
            $display("FAIL single_issue: got v=%b len=%0h a=%0h required 1 %0h %0h",
                     map_valid, map_vec_length, map_hva, c.len, c.a);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (map_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_strobe: got valid=%b required 0", map_valid);
        end
        wait_idle();
        exp_completed++;
        n_cmp++;
        if (pulses - p0 != 1) begin
            n_fail++;
            $display("FAIL single_pulses: got %0d required 1", pulses - p0);
        end
        n_cmp++;
        if (completed_count !== 16'(exp_completed) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got cnt=%0d busy=%b required %0d 0",
                     completed_count, busy, exp_completed);
        end
    endtask

    task automatic test_back_to_back();
        cmd_t cs[5];
        busy_cycles = 10;
        issued.delete();
        long_strobes = 0;
        foreach (cs[i]) cs[i] = rnd_cmd(1'b0);
        for (int i = 0; i < 4; i++) push_cmd(cs[i]);
        n_cmp++;
        if (cmd_ready !== 1'b0 || fifo_level !== 3'(FD)) begin
            n_fail++;
            $display("FAIL b2b_full: got ready=%b lvl=%0d required 0 %0d",
                     cmd_ready, fifo_level, FD);
        end
        push_cmd(cs[4]);
        n_cmp++;
        if (completed_count !== 16'(exp_completed + 1)) begin
            n_fail++;
            $display("FAIL b2b_fifth: got cnt=%0d required %0d",
                     completed_count, exp_completed + 1);
        end
        wait_idle();
        exp_completed += 5;
        n_cmp++;
        if (issued.size() != 5) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d issues required 5", issued.size());
        end
        for (int i = 0; i < 5 && i < issued.size(); i++) begin
            n_cmp++;
            if (issued[i] !== cs[i]) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: got %h required %h",
                         i, issued[i], cs[i]);
            end
        end
        n_cmp++;
        if (completed_count !== 16'(exp_completed) || long_strobes != 0) begin
            n_fail++;
            $display("FAIL b2b_done: got cnt=%0d long=%0d required %0d 0",
                     completed_count, long_strobes, exp_completed);
        end
    endtask

    task automatic test_zero_len();
        cmd_t c0;
        cmd_t c1;
        cmd_t cz;
        busy_cycles = 3;
        issued.delete();
        c0 = rnd_cmd(1'b0);
        c1 = rnd_cmd(1'b0);
        cz = rnd_cmd(1'b0);
        c0.len = W'(4);
        c1.len = W'(4);
        cz.len = '0;
        push_cmd(c0);
        push_cmd(cz);
        push_cmd(c1);
        wait_idle();
        exp_completed += 3;
        n_cmp++;
        if (issued.size() != 2) begin
            n_fail++;
            $display("FAIL zero_issues: got %0d required 2", issued.size());
        end else begin
            n_cmp++;
            if (issued[0] !== c0 || issued[1] !== c1) begin
                n_fail++;
                $display("FAIL zero_order: got %h %h required %h %h",
                         issued[0], issued[1], c0, c1);
            end
        end
        n_cmp++;
        if (completed_count !== 16'(exp_completed)) begin
            n_fail++;
            $display("FAIL zero_count: got %0d required %0d",
                     completed_count, exp_completed);
        end
    endtask

    task automatic test_done_low();
        cmd_t c = rnd_cmd(1'b0);
        int   p0 = pulses;
        busy_cycles = 4;
        hold_low = 1'b1;
        push_cmd(c);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (pulses != p0 || map_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_noissue: got %0d pulses required 0", pulses - p0);
        end
        hold_low = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (map_valid !== 1'b1 || map_hva !== c.a) begin
            n_fail++;
            $display("FAIL hold_issue: got v=%b a=%0h required 1 %0h",
                     map_valid, map_hva, c.a);
        end
        wait_idle();
        exp_completed++;
        n_cmp++;
        if (completed_count !== 16'(exp_completed)) begin
            n_fail++;
            $display("FAIL hold_count: got %0d required %0d",
                     completed_count, exp_completed);
        end
    endtask

    task automatic test_random();
        cmd_t exp_q[$];
        int   n = 25;
        rand_busy = 1'b1;
        issued.delete();
        long_strobes = 0;
        for (int i = 0; i < n; i++) begin
            cmd_t c = rnd_cmd(1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            push_cmd(c);
            if (c.len != '0) exp_q.push_back(c);
        end
        wait_idle();
        rand_busy = 1'b0;
        exp_completed += n;
        n_cmp++;
        if (issued.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_issues: got %0d required %0d",
                     issued.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < issued.size(); i++) begin
            n_cmp++;
            if (issued[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_order[%0d]: got %h required %h",
                         i, issued[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (completed_count !== 16'(exp_completed) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_done: got cnt=%0d busy=%b required %0d 0",
                     completed_count, busy, exp_completed);
        end
        n_cmp++;
        if (long_strobes != 0) begin
            n_fail++;
            $display("FAIL rand_strobe: got %0d long strobes required 0",
                     long_strobes);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        busy_cycles = 1000;
        for (int i = 0; i < 4; i++) push_cmd(rnd_cmd(1'b0));
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (fifo_level !== 3'd4 || map_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre: got lvl=%0d done=%b required 4 0",
                     fifo_level, map_done);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1 || map_valid !== 1'b0 ||
            {map_vec_length, map_hva, map_hvb, map_hvc} !== '0) begin
            n_fail++;
            $display("FAIL mid_map: got ready=%b v=%b len=%0h required 1 0 0",
                     cmd_ready, map_valid, map_vec_length);
        end
        n_cmp++;
        if ({busy, fifo_level, completed_count} !== '0) begin
            n_fail++;
            $display("FAIL mid_status: got busy=%b lvl=%0d cnt=%0d required 0",
                     busy, fifo_level, completed_count);
        end
        exp_completed = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        busy_cycles = 0;
        p0 = pulses;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (pulses != p0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: got %0d pulses busy=%b required 0 0",
                     pulses - p0, busy);
        end
    endtask

`ifdef DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        cmd_t c1 = rnd_cmd(1'b0);
        cmd_t c2 = rnd_cmd(1'b0);
        int   p0;
        busy_cycles = 1000;
        issued.delete();
        push_cmd(c1);
        push_cmd(c2);
        n_cmp++;
        if (map_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL to_issue: got v=%b required 1", map_valid);
        end
        repeat (19) @(posedge clk);
        #1;
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: got %b required 0", timeout);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (timeout !== 1'b1 || fifo_level !== 3'd1 ||
            completed_count !== 16'(exp_completed)) begin
            n_fail++;
            $display("FAIL to_fire: got to=%b lvl=%0d cnt=%0d required 1 1 %0d",
                     timeout, fifo_level, completed_count, exp_completed);
        end
        p0 = pulses;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (pulses != p0) begin
            n_fail++;
            $display("FAIL to_block: got %0d pulses required 0", pulses - p0);
        end
        busy_cycles = 0;
        @(posedge clk); #1;
        busy_cycles = 3;
        wait_idle();
        exp_completed++;
        n_cmp++;
        if (issued.size() != 2 || completed_count !== 16'(exp_completed) ||
            timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_recover: got n=%0d cnt=%0d to=%b required 2 %0d 1",
                     issued.size(), completed_count, timeout, exp_completed);
        end else begin
            n_cmp++;
            if (issued[0] !== c1 || issued[1] !== c2) begin
                n_fail++;
                $display("FAIL to_order: got %h %h required %h %h",
                         issued[0], issued[1], c1, c2);
            end
        end
    endtask
`endif

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        pulses         = 0;
        long_strobes   = 0;
        prev_valid     = 1'b0;
        hold_low       = 1'b0;
        rand_busy      = 1'b0;
        busy_cycles    = 10;
        exp_completed  = 0;
        cmd_valid      = 1'b0;
        cmd_vec_length = '0;
        cmd_hva        = '0;
        cmd_hvb        = '0;
        cmd_hvc        = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_len();
        test_done_low();
        test_random();
        test_reset_mid();
`ifdef DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_bound: got no completion, required finish in time");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/bind_command_dispatcher.md
# bind_command_dispatcher

- Buffers bind-operation commands (vector length plus three hypervector base addresses) from the host/control plane in a small FIFO.
- Issues them one at a time to the bind kernel mapper over its `valid`/`done` handshake, i.e. it is the initiator side of the mapper's command interface.
- Tracks completion and exposes status.
- Sits between the control-plane command source and the mapper.

## Interface

Parameters:
- HV_ADDRESS_WIDTH, 20, width of vector length and hypervector addresses (matches mapper)
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 65535, watchdog limit per issued command (used only with DISPATCH_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  FIFO can accept; `!full`, combinational from FIFO count
- cmd_vec_length  in  HV_ADDRESS_WIDTH  number of words to bind
- cmd_hva, cmd_hvb, cmd_hvc  in  HV_ADDRESS_WIDTH each  operand A, operand B, result base addresses
- map_valid  out  1  single-cycle issue strobe to mapper
- map_vec_length, map_hva, map_hvb, map_hvc  out  HV_ADDRESS_WIDTH each  registered operands to mapper
- map_done  in  1  mapper done; high when mapper idle
- busy  out  1  FSM not in S_IDLE, or FIFO non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- completed_count  out  16  commands retired; wraps 0xFFFF→0
- timeout  out  1  sticky watchdog flag; exists only with DISPATCH_TIMEOUT_EN

## Operation

Enqueue:
- Push on `cmd_valid && cmd_ready` at a rising edge.
- `cmd_valid` while full is ignored; the host must hold it.

FSM states:
- **S_IDLE**
  - FIFO non-empty, head `vec_length==0` → pop, increment completed_count, stay in S_IDLE. The mapper is not touched.
  - FIFO non-empty, `map_done==1` → load map_* from head, set `map_valid<=1`, go to S_WAIT_ACK.
  - Otherwise hold.
- **S_WAIT_ACK**
  - Clear `map_valid` on entry edge (strobe is exactly one cycle).
  - On `map_done==0` → S_WAIT_DONE.
- **S_WAIT_DONE**
  - On `map_done==1` → pop head, increment completed_count, go to S_IDLE.

Operand and FIFO rules:
- map_* operands stay stable from the issue edge until the pop; they are not changed in S_WAIT_*.
- FIFO push and pop may coincide; fifo_level is unchanged in that case.
- A push is only accepted when cmd_ready was high before the edge, even if a pop occurs on the same edge.

## Timing

- Reset values:
  - cmd_ready=1, map_valid=0, map_*=0, busy=0, fifo_level=0, completed_count=0, timeout=0.
  - FSM in S_IDLE, FIFO emptied.
- Reset asserted mid-command:
  - All state is dropped immediately.
  - The mapper is not notified.
  - The first issue after reset still waits for `map_done==1`.
- Latency, push at edge T into empty FIFO with mapper idle:
  - map_valid high from edge T+1 to T+2.
  - Mapper drops done after T+2.
  - S_WAIT_DONE entered at T+3.
- Retire: pop/count update on the first edge at which map_done is seen high in S_WAIT_DONE. The next issue is at the following edge, giving a minimum 1-cycle gap between strobes.
- Zero-length command: retired 1 edge after reaching the head.

## Configuration

- Macro: `DISPATCH_TIMEOUT_EN`.
- Defined:
  - A 16-bit (or wider if needed) counter clears on issue and counts in S_WAIT_ACK/S_WAIT_DONE.
  - Reaching TIMEOUT_CYCLES sets sticky `timeout`, pops the head without incrementing completed_count, and returns to S_IDLE.
  - S_IDLE's `map_done==1` guard then blocks further issue until the mapper recovers.
  - `timeout` clears only on reset.
- Undefined: no counter, no `timeout` port; the FSM waits indefinitely.

## Structure

- Package `hv_dispatch_pkg`:
  - `DispatchState_t` enum (S_IDLE, S_WAIT_ACK, S_WAIT_DONE).
  - `BindCmd_t` packed struct {vec_length, hva, hvb, hvc}, parameterised via HV_ADDRESS_WIDTH constant.
- Sub-module `hv_cmd_fifo`:
  - Synchronous FIFO of `BindCmd_t`, depth FIFO_DEPTH.
  - Pointers are $clog2(FIFO_DEPTH) bits with wrap; a separate count drives full/empty/level.
  - Head is readable combinationally (show-ahead).

## Test plan

- Single command {len=8, hva=0x100, hvb=0x200, hvc=0x300}, mapper model drops done 1 cycle after valid and raises it 10 cycles later → exactly one map_valid pulse with those operands; completed_count=1; busy low afterwards.
- Push 5 commands back-to-back with FIFO_DEPTH=4 and slow mapper → cmd_ready low after the 4th push; 5th accepted after the first retire; issue order matches push order; completed_count=5.
- Zero-length command between two len=4 commands → no map_valid for it; completed_count increments by 3 total.
- map_done held low at first push (mapper busy) → no map_valid until done rises; strobe then appears one edge later.
- reset_n pulsed low while in S_WAIT_DONE with 3 entries queued → all outputs at reset values asynchronously; fifo_level=0; no spurious map_valid after release.
- With DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=20, mapper never raises done → timeout set at cycle 20 after issue; head popped; completed_count unchanged; next command not issued while map_done=0.
